stopwatch_lap_mux: RTL and testbench

Parametrised multi-digit stopwatch with a lap/split function and a multiplexed 7-segment driver. It takes two raw push-buttons (start/stop, lap/clear), synchronises and debounces them, and runs a cascaded per-digit counter chain (tenths, seconds, minutes, ...). The chain is scanned onto a common-cathode-style 7-segment bank. It replaces the fixed 4-digit stopwatch on the 27 MHz board and generalises it in digit count, timebase, scan rate and debounce.

---
 rtl/stopwatch_lap_mux_if.sv | 22 ++
 rtl/stopwatch_lap_mux.sv | 196 +++++++++++++++++++
 tb/tb_stopwatch_lap_mux.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_lap_mux_if.sv
// rtl/stopwatch_lap_mux_if.sv - Raw buttons in, 7-segment bank and status flags out.
interface stopwatch_lap_mux_if #(
    parameter int DIGITS = 4
);
    logic              sys_startstopbtn;
    logic              sys_lapbtn;
    logic [7:0]        segLED;
    logic [DIGITS-1:0] segBlock;
    logic              running;
    logic              lap_active;
    logic              overflow;

    modport master (
        input  sys_startstopbtn, sys_lapbtn,
        output segLED, segBlock, running, lap_active, overflow
    );

    modport slave (
        output sys_startstopbtn, sys_lapbtn,
        input  segLED, segBlock, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_lap_mux.sv
// rtl/stopwatch_lap_mux.sv - Debounced start/lap stopwatch, cascaded digit chain, scanned 7-seg driver.
// Optional macro STOPWATCH_LEADING_ZERO_BLANK_EN blanks leading zero digits from digit 2 upward.
module stopwatch_lap_mux #(
    parameter int CLK_HZ          = 27_000_000,
    parameter int TICK_HZ         = 10,
    parameter int DIGITS          = 4,
    parameter int SCAN_HZ         = 240,
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    stopwatch_lap_mux_if.master io
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SLW      = $clog2(DIGITS);

    typedef enum logic [1:0] {ST_STOPPED, ST_RUNNING, ST_LAP} state_t;

    // Button index 0 is start/stop, index 1 is lap/clear.
    logic [1:0]             sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]             level_q, level_d, press_q, press_d;
    logic [1:0][DW-1:0]     db_cnt_q, db_cnt_d;
    state_t                 state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [DIGITS-1:0][3:0] digit_q, digit_d, snap_q, snap_d, digit_inc, disp_digits;
    logic                   overflow_q, overflow_d;
    logic [SW-1:0]          scan_q, scan_d;
    logic [SLW-1:0]         slot_q, slot_d;
    logic [7:0]             seg_q, seg_d;
    logic                   counting, tick, chain_wrap, blank;
    logic [3:0]             sel_val;

    function automatic logic [3:0] digit_max(input int i);
        return (i == 2 || i == 4) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // A level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        sync1_d = {io.sys_lapbtn, io.sys_startstopbtn};
        sync2_d = sync1_q;
        for (int b = 0; b < 2; b++) begin
            level_d[b]  = level_q[b];
            press_d[b]  = 1'b0;
            db_cnt_d[b] = '0;
            if (sync2_q[b] != level_q[b]) begin
                if (db_cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[b] = sync2_q[b];
                    press_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign counting = (state_q != ST_STOPPED);
    assign tick     = counting && (presc_q == PW'(TICK_DIV - 1));

    always_comb begin : digit_chain
        logic carry;
        carry     = tick;
        digit_inc = digit_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (digit_q[i] == digit_max(i)) begin
                    digit_inc[i] = 4'd0;
                end else begin
                    digit_inc[i] = digit_q[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
        chain_wrap = carry;
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        digit_d    = digit_q;
        snap_d     = snap_q;
        overflow_d = overflow_q;
        if (counting) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            digit_d = digit_inc;
            if (chain_wrap) overflow_d = 1'b1;
        end
        // Start is tested first so a simultaneous lap press is dropped.
        case (state_q)
            ST_STOPPED: begin
                if (press_q[0]) begin
                    state_d = ST_RUNNING;
                end else if (press_q[1]) begin
                    digit_d    = '0;
                    presc_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_RUNNING: begin
                if (press_q[0]) begin
                    state_d = ST_STOPPED;
                end else if (press_q[1]) begin
                    state_d = ST_LAP;
                    snap_d  = digit_q;
                end
            end
            ST_LAP: begin
                if (press_q[0])      state_d = ST_STOPPED;
                else if (press_q[1]) state_d = ST_RUNNING;
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // segLED is loaded from the slot being switched to, keeping it aligned with segBlock.
    always_comb begin
        scan_d      = scan_q + 1'b1;
        slot_d      = slot_q;
        seg_d       = seg_q;
        disp_digits = (state_q == ST_LAP) ? snap_q : digit_q;
        sel_val     = 4'd0;
        blank       = 1'b0;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d  = '0;
            slot_d  = (slot_q == SLW'(DIGITS - 1)) ? '0 : slot_q + 1'b1;
            sel_val = disp_digits[slot_d];
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
            blank = (int'(slot_d) >= 2);
            for (int i = 0; i < DIGITS; i++) begin
                if (i >= int'(slot_d) && disp_digits[i] != 4'd0) blank = 1'b0;
            end
`else
            blank = 1'b0;
`endif
            seg_d = {(int'(slot_d) == 1 || int'(slot_d) == 3),
                     blank ? 7'h00 : seg7(sel_val)};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            press_q    <= '0;
            db_cnt_q   <= '0;
            state_q    <= ST_STOPPED;
            presc_q    <= '0;
            digit_q    <= '0;
            snap_q     <= '0;
            overflow_q <= 1'b0;
            scan_q     <= '0;
            slot_q     <= '0;
            seg_q      <= 8'h00;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            press_q    <= press_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            presc_q    <= presc_d;
            digit_q    <= digit_d;
            snap_q     <= snap_d;
            overflow_q <= overflow_d;
            scan_q     <= scan_d;
            slot_q     <= slot_d;
            seg_q      <= seg_d;
        end
    end

    assign io.segLED     = seg_q;
    assign io.segBlock   = ~(DIGITS'(1) << slot_q);
    assign io.running    = counting;
    assign io.lap_active = (state_q == ST_LAP);
    assign io.overflow   = overflow_q;
endmodule

// File: tb/tb_stopwatch_lap_mux.sv
// tb/tb_stopwatch_lap_mux.sv - Stopwatch bench: count-based reference model plus directed and random button traffic.
module tb_stopwatch_lap_mux;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 200;
    localparam int SCAN_HZ = 100;
    localparam int DEB     = 4;
    localparam int D       = 4;
    localparam int TD      = CLK_HZ / TICK_HZ;
    localparam int SD      = CLK_HZ / SCAN_HZ;
    localparam int MAXC    = 10 * 10 * 6 * 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic raw_s = 1'b0;
    logic raw_l = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   shown[D];

    stopwatch_lap_mux_if #(.DIGITS(D)) bus ();
    assign bus.sys_startstopbtn = raw_s;
    assign bus.sys_lapbtn       = raw_l;

    stopwatch_lap_mux #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(D),
        .SCAN_HZ(SCAN_HZ), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .io        (bus)
    );

    always #5 clk = ~clk;

    function automatic int modulus(int i);
        return (i == 2 || i == 4) ? 6 : 10;
    endfunction

    function automatic int weight(int i);
        int w = 1;
        for (int j = 0; j < i; j++) w = w * modulus(j);
        return w;
    endfunction

    function automatic int digit_of(int v, int i);
        return (v / weight(i)) % modulus(i);
    endfunction

    function automatic logic [6:0] pattern(int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    function automatic int dec(logic [6:0] s);
        case (s)
            7'h3F: return 0;  7'h06: return 1;  7'h5B: return 2;  7'h4F: return 3;
            7'h66: return 4;  7'h6D: return 5;  7'h7D: return 6;  7'h07: return 7;
            7'h7F: return 8;  7'h6F: return 9;  7'h00: return 15; default: return 14;
        endcase
    endfunction

    function automatic logic [7:0] seg_of(int v, int i);
        logic [7:0] r;
        r[6:0] = pattern(digit_of(v, i));
        r[7]   = (i == 1 || i == 3);
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
        if (i >= 2 && v / weight(i) == 0) r[6:0] = 7'h00;
`endif
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: whole-stopwatch state as a tenths count; state 0 stopped, 1 running, 2 lap.
    bit         m_valid = 0;
    int         m_state, m_count, m_presc, m_snap, m_scan, m_slot;
    bit         m_ovf, m_lvl_s, m_lvl_l, m_prs_s, m_prs_l;
    logic [7:0] m_seg;
    bit         hs[DEB+2];
    bit         hl[DEB+2];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1; m_state = 0; m_count = 0; m_presc = 0; m_snap = 0;
            m_ovf = 0; m_scan = 0; m_slot = 0; m_seg = 8'h00;
            m_lvl_s = 0; m_lvl_l = 0; m_prs_s = 0; m_prs_l = 0;
            for (int i = 0; i < DEB + 2; i++) begin hs[i] = 0; hl[i] = 0; end
        end else begin
            int st0, c0;
            bit all_s, all_l;
            st0 = m_state;
            c0  = m_count;
            if (m_scan == SD - 1) begin
                m_scan = 0;
                m_slot = (m_slot + 1) % D;
                m_seg  = seg_of((st0 == 2) ? m_snap : c0, m_slot);
            end else begin
                m_scan++;
            end
            if (st0 != 0) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    m_count = (m_count + 1) % MAXC;
                    if (m_count == 0) m_ovf = 1;
                end else begin
                    m_presc++;
                end
            end
            if (m_prs_s) begin
                m_state = (st0 == 0) ? 1 : 0;
            end else if (m_prs_l) begin
                if (st0 == 0) begin m_count = 0; m_presc = 0; m_ovf = 0; end
                else if (st0 == 1) begin m_state = 2; m_snap = c0; end
                else m_state = 1;
            end
            // Synchronised sample seen now is the raw input from two edges ago.
            for (int i = DEB + 1; i > 0; i--) begin hs[i] = hs[i-1]; hl[i] = hl[i-1]; end
            hs[0] = raw_s;
            hl[0] = raw_l;
            all_s = 1; all_l = 1;
            for (int k = 2; k < DEB + 2; k++) begin
                if (hs[k] == m_lvl_s) all_s = 0;
                if (hl[k] == m_lvl_l) all_l = 0;
            end
            m_prs_s = 0; m_prs_l = 0;
            if (all_s) begin m_lvl_s = ~m_lvl_s; m_prs_s = m_lvl_s; end
            if (all_l) begin m_lvl_l = ~m_lvl_l; m_prs_l = m_lvl_l; end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [3:0] eb;
            eb = 4'hF;
            eb[m_slot] = 1'b0;
            chk("segLED", bus.segLED, m_seg);
            chk("segBlock", bus.segBlock, eb);
            chk("running", bus.running, m_state != 0);
            chk("lap_active", bus.lap_active, m_state == 2);
            chk("overflow", bus.overflow, m_ovf);
            for (int i = 0; i < D; i++) if (bus.segBlock[i] === 1'b0) shown[i] = dec(bus.segLED[6:0]);
        end
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(bit s, bit l, int n);
        if (s) raw_s = 1'b1;
        if (l) raw_l = 1'b1;
        cycles(n);
        raw_s = 1'b0;
        raw_l = 1'b0;
    endtask

    task automatic check_shown(string tag, int e0, int e1, int e2, int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
        if (e3 == 0) e[3] = 15;
        if (e3 == 0 && e2 == 0) e[2] = 15;
`endif
        for (int i = 0; i < D; i++) chk($sformatf("%s_shown%0d", tag, i), shown[i], e[i]);
    endtask

    task automatic pin_model(string tag, int v, int e0, int e1, int e2, int e3);
        chk({tag, "_model0"}, digit_of(v, 0), e0);
        chk({tag, "_model1"}, digit_of(v, 1), e1);
        chk({tag, "_model2"}, digit_of(v, 2), e2);
        chk({tag, "_model3"}, digit_of(v, 3), e3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        for (int i = 0; i < D; i++) shown[i] = -1;
        cycles(3);
        chk("rst_segBlock", bus.segBlock, 4'b1110);
        chk("rst_segLED", bus.segLED, 8'h00);
        chk("rst_running", bus.running, 0);
        rst_n = 1'b1;
        cycles(5);
        chk("post_rst_segLED", bus.segLED, 8'h00);
        chk("post_rst_segBlock", bus.segBlock, 4'b1110);
        chk("post_rst_overflow", bus.overflow, 0);

        // Start latency: 2 sync + 4 debounce + 1 edges.
        raw_s = 1'b1;
        cycles(6);
        chk("start_lat_6", bus.running, 0);
        cycles(1);
        chk("start_lat_7", bus.running, 1);
        cycles(3);
        raw_s = 1'b0;
        cycles(773);
        hold(1, 0, 10);
        cycles(60);
        chk("stop1_running", bus.running, 0);
        check_shown("stop1", 6, 5, 1, 0);
        pin_model("stop1", m_count, 6, 5, 1, 0);

        hold(1, 0, 3);
        cycles(30);
        chk("glitch_running", bus.running, 0);

        // Resume: prescaler residue from the first run must carry over.
        hold(1, 0, 10);
        cycles(34);
        hold(1, 0, 10);
        cycles(60);
        check_shown("resume", 5, 6, 1, 0);
        pin_model("resume", m_count, 5, 6, 1, 0);

        hold(1, 0, 10);
        cycles(90);
        hold(0, 1, 10);
        chk("lap_active_on", bus.lap_active, 1);
        cycles(60);
        check_shown("lap_frozen", 5, 8, 1, 0);
        pin_model("lap_snap", m_snap, 5, 8, 1, 0);
        hold(0, 1, 10);
        cycles(60);
        chk("lap2_active", bus.lap_active, 0);
        chk("lap2_running", bus.running, 1);
        hold(1, 1, 10);
        cycles(30);
        chk("both_running", bus.running, 0);
        chk("both_lap", bus.lap_active, 0);

        hold(0, 1, 10);
        cycles(60);
        check_shown("clear1", 0, 0, 0, 0);
        chk("clear1_ovf", bus.overflow, 0);

        hold(1, 0, 10);
        cycles(30055);
        hold(1, 0, 10);
        cycles(60);
        chk("wrap_ovf", bus.overflow, 1);
        chk("wrap_running", bus.running, 0);
        check_shown("wrap", 3, 1, 0, 0);
        pin_model("wrap", m_count, 3, 1, 0, 0);
        hold(0, 1, 10);
        cycles(60);
        chk("clear2_ovf", bus.overflow, 0);
        check_shown("clear2", 0, 0, 0, 0);

        seen = 0;
        for (int c = 0; c < 40; c++) begin
            cycles(1);
            chk("scan_dp", bus.segLED[7], (bus.segBlock == 4'b1101 || bus.segBlock == 4'b0111));
            case (bus.segBlock)
                4'b1110: seen |= 1;
                4'b1101: seen |= 2;
                4'b1011: seen |= 4;
                4'b0111: seen |= 8;
                default: seen |= 16;
            endcase
        end
        chk("scan_walk", seen, 15);

        for (int it = 0; it < 200; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                rst_n = 1'b0;
                cycles($urandom_range(1, 3));
                rst_n = 1'b1;
            end else if (r < 45) begin
                hold(1, 0, $urandom_range(1, 12));
            end else if (r < 88) begin
                hold(0, 1, $urandom_range(1, 12));
            end else begin
                hold(1, 1, $urandom_range(1, 12));
            end
            cycles($urandom_range(0, 40));
        end
        cycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
